// File: rtl/clock_reset_sequencer_pkg.sv
// Shared definitions for the clock/reset sequencer: FSM encoding, the
// processor period length and a small phase helper.
package clock_reset_sequencer_pkg;

  // One processor period spans this many master clocks. The clock-divider
  // blocks elsewhere in the codebase use the same constant.
  localparam int PERIOD  = 4;
  localparam int PHASE_W = 2;

  // Last phase of a period; the 3->0 transition is the period boundary.
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PERIOD - 1);

  // Sequencer states.
  //  SEQ_RESET : waiting for the synchronised reset release
  //  SEQ_HOLD  : counting the post-release hold time, sys_reset still high
  //  SEQ_RUN   : free-running derived clocks
  //  SEQ_PAUSE : single-step mode, parked at phase 0
  //  SEQ_STEP  : one stepped processor period in flight
  typedef enum logic [2:0] {
    SEQ_RESET = 3'd0,
    SEQ_HOLD  = 3'd1,
    SEQ_RUN   = 3'd2,
    SEQ_PAUSE = 3'd3,
    SEQ_STEP  = 3'd4
  } seq_state_t;

  // Phase that follows the given one, wrapping at the period length.
  function automatic logic [PHASE_W-1:0] phase_after(input logic [PHASE_W-1:0] cur);
    if (cur == LAST_PHASE) begin
      phase_after = '0;
    end else begin
      phase_after = cur + PHASE_W'(1);
    end
  endfunction

  // True when the given state is one in which the derived clocks toggle.
  function automatic logic is_clocking(input seq_state_t st);
    is_clocking = (st == SEQ_RUN) || (st == SEQ_STEP);
  endfunction

endpackage

// File: rtl/clock_reset_sequencer_reset_sync.sv
// Reset-release synchroniser: a chain of SYNC_STAGES flops cleared
// asynchronously by the active-low reset and filled with ones afterwards.
// Assertion is immediate; release reaches the output SYNC_STAGES rising
// edges after reset goes high.
module clock_reset_sequencer_reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  output logic released
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift ones into the chain once reset is high; clear it the instant reset drops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign released = chain[SYNC_STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// Clock and reset sequencer sitting upstream of the processor top level.
// Derives the imem/dmem/processor/regfile clocks from one master clock, all
// phase-aligned to a single 4-cycle phase counter, produces a synchronised
// active-high sys_reset with a programmable hold time, and offers a
// single-step debug mode.
//
// Step handshake (four-phase req/ack):
//  step_req is a level. A step is launched from PAUSE when step_req=1 and the
//  armed flag is set; launching clears armed. armed is set again on any clock
//  where step_req is seen at 0. step_ack pulses for one clock on the edge that
//  completes the stepped period (phase 3->0). Holding step_req high therefore
//  yields exactly one step; dropping it after the ack and raising it again
//  yields the next one. step_req outside PAUSE is ignored and leaves armed
//  untouched.
module clock_reset_sequencer
  import clock_reset_sequencer_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step_mode,
  input  logic       step_req,
  output logic       imem_clock,
  output logic       dmem_clock,
  output logic       processor_clock,
  output logic       regfile_clock,
  output logic       sys_reset,
  output logic [1:0] phase,
  output logic       running,
  output logic       step_ack,
  output logic [2:0] fsm_state
);

  // Hold counter compares against the last count value so that exactly
  // RST_HOLD_CYCLES clocks are spent in HOLD.
  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);

  seq_state_t         state;
  logic [7:0]         hold_cnt;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] next_phase;
  logic               dmem_q;
  logic               proc_q;
  logic               sys_reset_q;
  logic               running_q;
  logic               step_ack_q;
  logic               armed;
  logic               released;
  logic               period_end;

  clock_reset_sequencer_reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clock    (clock),
    .reset    (reset),
    .released (released)
  );

  // Next position in the processor period and whether this edge closes it.
  always_comb begin
    next_phase = phase_after(phase_q);
    period_end = is_clocking(state) && (phase_q == LAST_PHASE);
  end

  // Sequencer FSM with its counters, armed flag and registered outputs.
  // Derived clocks are loaded from next_phase on the same edge as phase, so
  // processor_clock rises on 1->2 and falls on 3->0 and nothing is gated.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= SEQ_RESET;
      hold_cnt    <= '0;
      phase_q     <= '0;
      dmem_q      <= 1'b0;
      proc_q      <= 1'b0;
      sys_reset_q <= 1'b1;
      running_q   <= 1'b0;
      step_ack_q  <= 1'b0;
      armed       <= 1'b0;
    end else begin
      step_ack_q <= 1'b0;

      // Re-arm whenever the request is seen low; this is independent of state.
      if (!step_req) begin
        armed <= 1'b1;
      end

      unique case (state)
        SEQ_RESET: begin
          if (released) begin
            state    <= SEQ_HOLD;
            hold_cnt <= '0;
          end
        end

        SEQ_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            sys_reset_q <= 1'b0;
            if (step_mode) begin
              state <= SEQ_PAUSE;
            end else begin
              state     <= SEQ_RUN;
              running_q <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        SEQ_PAUSE: begin
          // Leaving step mode takes priority over a pending step request.
          if (!step_mode) begin
            state     <= SEQ_RUN;
            running_q <= 1'b1;
          end else if (step_req && armed) begin
            state     <= SEQ_STEP;
            running_q <= 1'b1;
            armed     <= 1'b0;
          end
        end

        SEQ_RUN, SEQ_STEP: begin
          phase_q <= next_phase;
          dmem_q  <= next_phase[0];
          proc_q  <= next_phase[1];
          // step_mode only matters at the period boundary, so a mid-period
          // change never truncates the period in flight.
          if (period_end) begin
            if (state == SEQ_STEP) begin
              step_ack_q <= 1'b1;
            end
            if (step_mode) begin
              state     <= SEQ_PAUSE;
              running_q <= 1'b0;
            end else begin
              state     <= SEQ_RUN;
              running_q <= 1'b1;
            end
          end
        end

        default: begin
          state <= SEQ_RESET;
        end
      endcase
    end
  end

  assign imem_clock      = clock;
  assign dmem_clock      = dmem_q;
  assign processor_clock = proc_q;
  assign regfile_clock   = proc_q;
  assign sys_reset       = sys_reset_q;
  assign phase           = phase_q;
  assign running         = running_q;
  assign step_ack        = step_ack_q;
  assign fsm_state       = state;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer: randomized step/mode stimulus compared
// cycle by cycle against a period-position model, plus directed reset,
// latency, step handshake and parameter sweep scenarios.
module tb_clock_reset_sequencer;

  localparam int TB_PERIOD = 4;
  localparam int MAIN_S = 2;
  localparam int MAIN_H = 8;
  localparam int SW1_S = 3;
  localparam int SW1_H = 1;
  localparam int SW2_S = 3;
  localparam int SW2_H = 255;

  localparam int M_PAUSE = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;

  logic       clock;
  logic       reset;
  logic       step_mode;
  logic       step_req;
  logic       imem_clock, dmem_clock, processor_clock, regfile_clock;
  logic       sys_reset, running, step_ack;
  logic [1:0] phase;
  logic [2:0] fsm_state;

  logic       s1_imem, s1_dmem, s1_proc, s1_rf, s1_sr, s1_run, s1_ack;
  logic [1:0] s1_phase;
  logic [2:0] s1_st;
  logic       s2_imem, s2_dmem, s2_proc, s2_rf, s2_sr, s2_run, s2_ack;
  logic [1:0] s2_phase;
  logic [2:0] s2_st;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode of operation, position within the period, armed flag, ack.
  int m_mode;
  int m_pos;
  bit m_armed;
  bit m_ack;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  clock_reset_sequencer #(.RST_HOLD_CYCLES(MAIN_H), .SYNC_STAGES(MAIN_S)) dut (
    .clock(clock), .reset(reset), .step_mode(step_mode), .step_req(step_req),
    .imem_clock(imem_clock), .dmem_clock(dmem_clock), .processor_clock(processor_clock),
    .regfile_clock(regfile_clock), .sys_reset(sys_reset), .phase(phase),
    .running(running), .step_ack(step_ack), .fsm_state(fsm_state)
  );

  clock_reset_sequencer #(.RST_HOLD_CYCLES(SW1_H), .SYNC_STAGES(SW1_S)) dut_sw1 (
    .clock(clock), .reset(reset), .step_mode(step_mode), .step_req(step_req),
    .imem_clock(s1_imem), .dmem_clock(s1_dmem), .processor_clock(s1_proc),
    .regfile_clock(s1_rf), .sys_reset(s1_sr), .phase(s1_phase),
    .running(s1_run), .step_ack(s1_ack), .fsm_state(s1_st)
  );

  clock_reset_sequencer #(.RST_HOLD_CYCLES(SW2_H), .SYNC_STAGES(SW2_S)) dut_sw2 (
    .clock(clock), .reset(reset), .step_mode(step_mode), .step_req(step_req),
    .imem_clock(s2_imem), .dmem_clock(s2_dmem), .processor_clock(s2_proc),
    .regfile_clock(s2_rf), .sys_reset(s2_sr), .phase(s2_phase),
    .running(s2_run), .step_ack(s2_ack), .fsm_state(s2_st)
  );

  // Reference model: one master-clock edge with the inputs present before it.
  function automatic void model_edge(input bit mode, input bit req);
    m_ack = 1'b0;
    if (m_mode == M_PAUSE) begin
      if (!mode) begin
        m_mode = M_RUN;
      end else if (req && m_armed) begin
        m_mode  = M_STEP;
        m_armed = 1'b0;
      end
    end else begin
      m_pos = (m_pos + 1) % TB_PERIOD;
      if (m_pos == 0) begin
        if (m_mode == M_STEP) m_ack = 1'b1;
        m_mode = mode ? M_PAUSE : M_RUN;
      end
    end
    if (!req) m_armed = 1'b1;
  endfunction

  // Expected {sys_reset, phase, dmem, proc, regfile, running, step_ack} after release.
  function automatic logic [7:0] exp_vec();
    logic [1:0] p;
    logic       hi;
    p  = 2'(m_pos);
    hi = (m_pos >= TB_PERIOD / 2);
    return {1'b0, p, p[0], hi, hi, (m_mode != M_PAUSE), m_ack};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {sys_reset, phase, dmem_clock, processor_clock, regfile_clock, running, step_ack};
  endfunction

  // driver: one clock with the given inputs, model advanced, sampled 1 unit after the edge
  task automatic cycle(input bit mode, input bit req);
    step_mode = mode;
    step_req  = req;
    @(posedge clock);
    model_edge(mode, req);
    #1;
  endtask

  // Assert reset, release it just after an edge and measure each DUT's release
  // latency in edges counted from the edge that first samples reset high.
  task automatic release_reset(input bit mode, input bit wait_all, input int budget,
                               output int lat0, output int lat1, output int lat2);
    step_mode = mode;
    step_req  = 1'b0;
    reset     = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    lat0 = -1; lat1 = -1; lat2 = -1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clock);
      if (lat0 >= 0) model_edge(mode, 1'b0);
      #1;
      if (lat0 < 0) begin
        if (sys_reset === 1'b0) begin
          lat0    = k;
          m_mode  = mode ? M_PAUSE : M_RUN;
          m_pos   = 0;
          m_armed = 1'b1;
          m_ack   = 1'b0;
        end else begin
          vectors++;
          if ({sys_reset, phase, dmem_clock, processor_clock, running, step_ack} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL hold_quiet: edge %0d got %b want 1000000", k,
                     {sys_reset, phase, dmem_clock, processor_clock, running, step_ack});
          end
        end
      end
      if (lat1 < 0 && s1_sr === 1'b0) lat1 = k;
      if (lat2 < 0 && s2_sr === 1'b0) lat2 = k;
      if (lat0 >= 0 && (!wait_all || (lat1 >= 0 && lat2 >= 0))) break;
    end
  endtask

  task automatic test_reset();
    step_mode = 1'b0;
    step_req  = 1'b0;
    reset     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({sys_reset, phase, dmem_clock, processor_clock, regfile_clock, running, step_ack} !== 8'b10000000) begin
      miscompares++;
      $display("FAIL reset_values: got %b want 10000000",
               {sys_reset, phase, dmem_clock, processor_clock, regfile_clock, running, step_ack});
    end
    vectors++;
    if (imem_clock !== 1'b1) begin
      miscompares++;
      $display("FAIL imem_high: got %b want 1", imem_clock);
    end
    @(negedge clock); #1;
    vectors++;
    if (imem_clock !== 1'b0) begin
      miscompares++;
      $display("FAIL imem_low: got %b want 0", imem_clock);
    end
  endtask

  task automatic test_free_run();
    int l0, l1, l2;
    int proc_hi, dmem_hi;
    release_reset(1'b0, 1'b0, 100, l0, l1, l2);
    vectors++;
    if (l0 !== MAIN_S + MAIN_H) begin
      miscompares++;
      $display("FAIL release_latency: got %0d want %0d", l0, MAIN_S + MAIN_H);
    end
    proc_hi = 0;
    dmem_hi = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)));
      proc_hi += int'(processor_clock);
      dmem_hi += int'(dmem_clock);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL free_run: cycle %0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (proc_hi !== 12 || dmem_hi !== 12) begin
      miscompares++;
      $display("FAIL duty: got proc=%0d dmem=%0d want 12/12", proc_hi, dmem_hi);
    end
  endtask

  task automatic test_mode_change();
    int acks;
    for (int i = 0; i < 8 && m_pos != 1; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL mode_to_pause: cycle %0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if ({phase, running, processor_clock} !== 4'b0000) begin
      miscompares++;
      $display("FAIL parked: got %b want 0000", {phase, running, processor_clock});
    end
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1);
      acks += int'(step_ack);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL pause_to_run: cycle %0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (acks !== 0 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL run_wins: got acks=%0d running=%b want 0/1", acks, running);
    end
  endtask

  task automatic test_step();
    int acks, proc_hi;
    for (int i = 0; i < 8 && m_mode != M_PAUSE; i++) cycle(1'b1, 1'b0);
    acks = 0;
    proc_hi = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, i == 0);
      acks += int'(step_ack);
      proc_hi += int'(processor_clock);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL step: cycle %0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (acks !== 1 || proc_hi !== 2 || phase !== 2'd0) begin
      miscompares++;
      $display("FAIL step_count: got acks=%0d proc_hi=%0d phase=%0d want 1/2/0", acks, proc_hi, phase);
    end
  endtask

  task automatic test_held_request();
    int acks;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1);
      acks += int'(step_ack);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL held_req: cycle %0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (acks !== 1) begin
      miscompares++;
      $display("FAIL held_one_ack: got %0d want 1", acks);
    end
    acks = 0;
    repeat (3) cycle(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1);
      acks += int'(step_ack);
    end
    vectors++;
    if (acks !== 1) begin
      miscompares++;
      $display("FAIL second_step: got %0d want 1", acks);
    end
  endtask

  task automatic test_async_reset();
    int l0, l1, l2;
    for (int i = 0; i < 16 && !(m_mode == M_RUN && m_pos == 2); i++) cycle(1'b0, 1'b0);
    vectors++;
    if (phase !== 2'd2) begin
      miscompares++;
      $display("FAIL pre_reset_phase: got %0d want 2", phase);
    end
    #3 reset = 1'b0;
    #1;
    vectors++;
    if ({sys_reset, phase, dmem_clock, processor_clock, running, step_ack} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL async_reset: got %b want 1000000",
               {sys_reset, phase, dmem_clock, processor_clock, running, step_ack});
    end
    release_reset(1'b0, 1'b0, 100, l0, l1, l2);
    vectors++;
    if (l0 !== MAIN_S + MAIN_H) begin
      miscompares++;
      $display("FAIL rerelease_latency: got %0d want %0d", l0, MAIN_S + MAIN_H);
    end
  endtask

  task automatic test_param_sweep();
    int l0, l1, l2;
    release_reset(1'b0, 1'b1, 400, l0, l1, l2);
    vectors++;
    if (l1 !== SW1_S + SW1_H) begin
      miscompares++;
      $display("FAIL sweep_h1: got %0d want %0d", l1, SW1_S + SW1_H);
    end
    vectors++;
    if (l2 !== SW2_S + SW2_H) begin
      miscompares++;
      $display("FAIL sweep_h255: got %0d want %0d", l2, SW2_S + SW2_H);
    end
    vectors++;
    if (l0 !== MAIN_S + MAIN_H) begin
      miscompares++;
      $display("FAIL sweep_main: got %0d want %0d", l0, MAIN_S + MAIN_H);
    end
  endtask

  task automatic test_random();
    int l0, l1, l2;
    bit mode, req;
    release_reset(1'b0, 1'b0, 100, l0, l1, l2);
    mode = 1'b0;
    req  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) req = ~req;
      cycle(mode, req);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random: cycle %0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    step_mode = 1'b0;
    step_req  = 1'b0;
    m_mode    = M_PAUSE;
    m_pos     = 0;
    m_armed   = 1'b0;
    m_ack     = 1'b0;
    test_reset();
    test_free_run();
    test_mode_change();
    test_step();
    test_held_request();
    test_async_reset();
    test_param_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
